msrv32_iadder_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational immediate adder; computes branch/jump/load-store target addresses.
- Computes base plus immediate, where base is the PC or RS1, through a registered elastic pipeline with valid/ready handshake, flush and a transaction tag.
- Sits between decode/operand fetch and the branch unit / LSU. Lets the address path be retimed without changing the arithmetic.

---
 rtl/msrv32_iadder_pipe_if.sv | 33 +++
 rtl/msrv32_iadder_pipe.sv | 90 +++++++++
 tb/tb_msrv32_iadder_pipe.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/msrv32_iadder_pipe_if.sv
// Handshake and operand bundle for the pipelined immediate adder.
// The DUT takes the slave modport; the producer/consumer side takes master.
interface msrv32_iadder_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             flush_in;
  logic             valid_in;
  logic             ready_out;
  logic [XLEN-1:0]  pc_in;
  logic [XLEN-1:0]  rs_1_in;
  logic [XLEN-1:0]  imm_in;
  logic             iadder_src_in;
  logic             jalr_in;
  logic [TAG_W-1:0] tag_in;
  logic             valid_out;
  logic             ready_in;
  logic [XLEN-1:0]  iadder_out;
  logic [TAG_W-1:0] tag_out;
  logic             misaligned_out;

  modport master (
    output flush_in, valid_in, pc_in, rs_1_in, imm_in, iadder_src_in,
           jalr_in, tag_in, ready_in,
    input  ready_out, valid_out, iadder_out, tag_out, misaligned_out
  );

  modport slave (
    input  flush_in, valid_in, pc_in, rs_1_in, imm_in, iadder_src_in,
           jalr_in, tag_in, ready_in,
    output ready_out, valid_out, iadder_out, tag_out, misaligned_out
  );
endinterface

// File: rtl/msrv32_iadder_pipe.sv
// Elastic pipelined target-address adder: (pc or rs1) + imm, jalr clears bit 0.
// Optional misalignment flag is built when MSRV32_IADDER_MISALIGN_EN is defined.
module msrv32_iadder_pipe #(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  msrv32_iadder_pipe_if.slave  bus
);
  localparam int LAST = PIPE_STAGES - 1;

  function automatic logic [XLEN-1:0] f_target(
    input logic            src,
    input logic            jalr,
    input logic [XLEN-1:0] pc,
    input logic [XLEN-1:0] rs1,
    input logic [XLEN-1:0] imm
  );
    logic [XLEN-1:0] s;
    s = (src ? rs1 : pc) + imm;
    if (jalr) s[0] = 1'b0;
    return s;
  endfunction

  logic [PIPE_STAGES-1:0] r_vld;
  logic [XLEN-1:0]        r_sum [PIPE_STAGES];
  logic [TAG_W-1:0]       r_tag [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] w_adv;
  logic [XLEN-1:0]        w_sum;

  assign w_sum = f_target(bus.iadder_src_in, bus.jalr_in, bus.pc_in,
                          bus.rs_1_in, bus.imm_in);

  // A stage may load when the consumer takes the result or any hole exists at or after it.
  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_adv
    assign w_adv[k] = bus.ready_in || !(&r_vld[LAST:k]);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_vld <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        r_sum[k] <= '0;
        r_tag[k] <= '0;
      end
    end else if (bus.flush_in) begin
      r_vld <= '0;
    end else begin
      if (w_adv[0]) begin
        r_vld[0] <= bus.valid_in;
        r_sum[0] <= w_sum;
        r_tag[0] <= bus.tag_in;
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (w_adv[k]) begin
          r_vld[k] <= r_vld[k-1];
          r_sum[k] <= r_sum[k-1];
          r_tag[k] <= r_tag[k-1];
        end
      end
    end
  end

  assign bus.ready_out  = w_adv[0];
  assign bus.valid_out  = r_vld[LAST];
  assign bus.iadder_out = r_sum[LAST];
  assign bus.tag_out    = r_tag[LAST];

`ifdef MSRV32_IADDER_MISALIGN_EN
  logic [PIPE_STAGES-1:0] r_mis;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_mis <= '0;
    end else if (!bus.flush_in) begin
      if (w_adv[0]) r_mis[0] <= w_sum[1];
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (w_adv[k]) r_mis[k] <= r_mis[k-1];
      end
    end
  end

  assign bus.misaligned_out = r_mis[LAST];
`else
  assign bus.misaligned_out = 1'b0;
`endif

endmodule

// File: tb/tb_msrv32_iadder_pipe.sv
// Scoreboard bench for msrv32_iadder_pipe: directed cases plus random traffic.
module tb_msrv32_iadder_pipe;
  localparam int XLEN = 32;
  localparam int P    = 2;
  localparam int TW   = 4;

  typedef struct {
    logic [XLEN-1:0] addr;
    logic [TW-1:0]   tag;
    logic            mis;
    int              cyc;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   head_seen = 0;
  exp_t q[$];

  msrv32_iadder_pipe_if #(.XLEN(XLEN), .TAG_W(TW)) bus ();

  msrv32_iadder_pipe #(.XLEN(XLEN), .PIPE_STAGES(P), .TAG_W(TW)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: address arithmetic done in 64 bits and reduced modulo 2^32.
  function automatic exp_t model(input logic src, input logic jalr,
                                 input logic [31:0] pc, input logic [31:0] rs1,
                                 input logic [31:0] imm, input logic [TW-1:0] tag, input int c);
    exp_t e;
    longint unsigned base, t;
    base  = src ? longint'(rs1) : longint'(pc);
    t     = (base + longint'(imm)) % 64'h1_0000_0000;
    if (jalr && (t % 2 == 1)) t = t - 1;
    e.addr = t[31:0];
    e.tag  = tag;
`ifdef MSRV32_IADDER_MISALIGN_EN
    e.mis  = ((t / 2) % 2) == 1;
`else
    e.mis  = 1'b0;
`endif
    e.cyc  = c;
    return e;
  endfunction

  // Monitor: samples mid-cycle, while inputs and outputs are stable before the next edge.
  always @(negedge clk_in) begin
    cyc++;
    if (rst_in) begin
      q.delete();
      head_seen = 0;
    end else begin
      chk("ready_out_vs_occupancy", bus.ready_out, (q.size() < P) || bus.ready_in);
      if (bus.valid_out) begin
        if (q.size() == 0) begin
          chk("unexpected_output_tag", bus.tag_out, 64'hDEAD);
        end else begin
          chk("iadder_out", bus.iadder_out, q[0].addr);
          chk("tag_out", bus.tag_out, q[0].tag);
          chk("misaligned_out", bus.misaligned_out, q[0].mis);
          if (!head_seen) begin
            chk("latency_min", cyc >= q[0].cyc + P, 1);
            head_seen = 1;
          end
          if (bus.ready_in) begin
            void'(q.pop_front());
            head_seen = 0;
          end
        end
      end
      if (bus.flush_in) begin
        q.delete();
        head_seen = 0;
      end else if (bus.valid_in && bus.ready_out) begin
        q.push_back(model(bus.iadder_src_in, bus.jalr_in, bus.pc_in, bus.rs_1_in,
                          bus.imm_in, bus.tag_in, cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_op(input logic src, input logic jalr, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] imm, input logic [TW-1:0] tag);
    bus.iadder_src_in = src;
    bus.jalr_in       = jalr;
    bus.pc_in         = pc;
    bus.rs_1_in       = rs1;
    bus.imm_in        = imm;
    bus.tag_in        = tag;
  endtask

  // Presents one op and returns 1ns after the edge at which it was accepted.
  task automatic send(input logic src, input logic jalr, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] imm, input logic [TW-1:0] tag);
    bit ok = 0;
    set_op(src, jalr, pc, rs1, imm, tag);
    bus.valid_in = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_in);
      if (bus.ready_out) ok = 1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    step();
    bus.valid_in = 1'b0;
  endtask

  // Called right after an op enters an empty pipe: must appear exactly P-1 edges later.
  task automatic expect_latency(input string name, input logic [31:0] addr, input logic [TW-1:0] tag);
    for (int i = 1; i < P; i++) begin
      chk({name, "_not_early"}, bus.valid_out, 0);
      step();
    end
    chk({name, "_valid"}, bus.valid_out, 1);
    chk({name, "_addr"}, bus.iadder_out, addr);
    chk({name, "_tag"}, bus.tag_out, tag);
  endtask

  task automatic drain(input int n);
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    repeat (n) step();
    chk("drained", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.flush_in = 1'b0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    set_op(0, 0, 0, 0, 0, 0);
    #3;
    chk("rst_valid_out", bus.valid_out, 0);
    chk("rst_iadder_out", bus.iadder_out, 0);
    chk("rst_tag_out", bus.tag_out, 0);
    chk("rst_misaligned_out", bus.misaligned_out, 0);
    step();
    rst_in = 1'b0;
    step();

    // Basic PC mode
    send(0, 0, 32'h1234_5678, 32'h0, 32'h0000_0001, 4'd3);
    expect_latency("pc_mode", 32'h1234_5679, 4'd3);
    drain(3);

    // RS1 mode with wrap-around, then a plain add
    send(1, 0, 32'h0, 32'hFFFF_FFFF, 32'h0000_0002, 4'd4);
    expect_latency("rs1_wrap", 32'h0000_0001, 4'd4);
    drain(3);
    send(1, 0, 32'h0, 32'h8765_4321, 32'h0000_0001, 4'd5);
    expect_latency("rs1_plain", 32'h8765_4322, 4'd5);
    drain(3);

    // JALR: bit 0 cleared; misalignment carried by the scoreboard entry
    send(1, 1, 32'h0, 32'h0000_1000, 32'h0000_0003, 4'd6);
    expect_latency("jalr_a", 32'h0000_1002, 4'd6);
`ifdef MSRV32_IADDER_MISALIGN_EN
    chk("jalr_a_mis", bus.misaligned_out, 1);
`endif
    drain(3);
    send(1, 1, 32'h0, 32'h0000_1000, 32'h0000_0005, 4'd7);
    expect_latency("jalr_b", 32'h0000_1004, 4'd7);
    chk("jalr_b_mis", bus.misaligned_out, 0);
    drain(3);

    // Back-pressure: three ops with the consumer stalled
    bus.ready_in = 1'b0;
    set_op(0, 0, $urandom, $urandom, $urandom, 4'd1);
    bus.valid_in = 1'b1;
    step();
    set_op(1, 0, $urandom, $urandom, $urandom, 4'd2);
    step();
    chk("bp_full_ready_out", bus.ready_out, 0);
    chk("bp_head_valid", bus.valid_out, 1);
    chk("bp_head_tag", bus.tag_out, 1);
    set_op(0, 1, $urandom, $urandom, $urandom, 4'd3);
    repeat (3) begin
      step();
      chk("bp_hold_ready_out", bus.ready_out, 0);
      chk("bp_hold_tag", bus.tag_out, 1);
    end
    bus.ready_in = 1'b1;
    step();
    bus.valid_in = 1'b0;
    drain(4);

    // Flush with two ops in flight and a simultaneous input
    bus.ready_in = 1'b0;
    send(0, 0, 32'h100, 0, 32'h4, 4'd8);
    send(0, 0, 32'h200, 0, 32'h4, 4'd9);
    set_op(0, 0, 32'h300, 0, 32'h4, 4'd15);
    bus.valid_in = 1'b1;
    bus.flush_in = 1'b1;
    step();
    bus.flush_in = 1'b0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    repeat (3) begin
      chk("flush_valid_out", bus.valid_out, 0);
      step();
    end
    send(0, 0, 32'h400, 0, 32'h8, 4'd10);
    expect_latency("post_flush", 32'h408, 4'd10);
    drain(3);

    // Random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      set_op($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom,
             ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 7) : $urandom,
             $urandom_range(0, 15));
      bus.valid_in = ($urandom_range(0, 3) != 0);
      bus.ready_in = ($urandom_range(0, 2) != 0);
      bus.flush_in = ($urandom_range(0, 39) == 0);
      step();
    end
    bus.flush_in = 1'b0;
    drain(5);

    // Asynchronous reset between edges while streaming
    bus.ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_op(0, 0, 32'h1000 + i, 0, 32'h10, i[TW-1:0] + 4'd1);
      bus.valid_in = 1'b1;
      step();
    end
    chk("pre_reset_valid", bus.valid_out, 1);
    #2;
    rst_in = 1'b1;
    bus.valid_in = 1'b0;
    #1;
    chk("async_rst_valid_out", bus.valid_out, 0);
    chk("async_rst_iadder_out", bus.iadder_out, 0);
    chk("async_rst_tag_out", bus.tag_out, 0);
    step();
    step();
    rst_in = 1'b0;
    chk("post_rst_valid_out", bus.valid_out, 0);
    step();
    chk("post_rst_idle", bus.valid_out, 0);
    send(1, 0, 0, 32'h2000, 32'h20, 4'd12);
    expect_latency("post_reset", 32'h2020, 4'd12);
    drain(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
